// File: rtl/ctrnn_step_sequencer.sv
// Euler-step controller that closes the UnitNeuron feedback loop and streams every
// captured state into a valid/ready trace FIFO. Optional NAN_GUARD_EN stops a run on Inf/NaN.
module ctrnn_step_sequencer #(
  parameter int STEPS_W    = 16,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        y_init,
  input  logic [STEPS_W-1:0] n_steps,
  output logic [31:0]        neuron_y_t,
  input  logic [31:0]        neuron_y_next,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STEPS_W-1:0] step_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [STEPS_W-1:0] out_step
);

  localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LAT_W-1:0] LAT_RELOAD    = LAT_W'(LAT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        y_t_q;
  logic [STEPS_W-1:0] step_q;
  logic [STEPS_W-1:0] step_next;
  logic [STEPS_W-1:0] n_steps_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic               start_ok;
  logic               push;
  logic               pop;

  logic [31:0]        fifo_data [FIFO_DEPTH];
  logic [STEPS_W-1:0] fifo_step [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_full;

`ifdef NAN_GUARD_EN
  logic nan_hit;
  logic next_nonfinite;
  logic err_q;

  assign next_nonfinite = (neuron_y_next[30:23] == 8'hFF);
`endif

  assign step_next = step_q + STEPS_W'(1);
  // Full comes straight from the registered count, so a same-cycle pop never frees a slot for a push.
  assign fifo_full = (fifo_count == FIFO_FULL_CNT);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    start_ok = 1'b0;
    push     = 1'b0;
`ifdef NAN_GUARD_EN
    nan_hit  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (n_steps == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt == '0) state_d = S_CAPT;
      end
      S_CAPT: begin
`ifdef NAN_GUARD_EN
        if (next_nonfinite) begin
          nan_hit = 1'b1;
          state_d = S_DONE;
        end else
`endif
        if (!fifo_full) begin
          push    = 1'b1;
          state_d = (step_next == n_steps_q) ? S_DONE : S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and step datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      y_t_q     <= '0;
      step_q    <= '0;
      n_steps_q <= '0;
      lat_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        step_q    <= '0;
        n_steps_q <= n_steps;
        if (n_steps != '0) begin
          y_t_q   <= y_init;
          lat_cnt <= LAT_RELOAD;
        end
      end else if (state_q == S_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end else if (push) begin
        y_t_q   <= neuron_y_next;
        step_q  <= step_next;
        lat_cnt <= LAT_RELOAD;
      end
    end
  end

`ifdef NAN_GUARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (nan_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign neuron_y_t = y_t_q;
  assign step_count = step_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

  // ---------------------------------------------------------------------------
  // Trace FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; outputs are masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= neuron_y_next;
      fifo_step[wr_ptr] <= step_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_data = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_step = out_valid ? fifo_step[rd_ptr] : '0;

endmodule

// File: tb/tb_ctrnn_step_sequencer.sv
// Self-checking bench for ctrnn_step_sequencer: stub neuron, trace model queue,
// randomized runs, backpressure, zero-step, start-while-busy, mid-run reset, NaN handling.
module tb_ctrnn_step_sequencer;

  localparam int STEPS_W    = 16;
  localparam int LAT        = 4;
  localparam int FIFO_DEPTH = 8;
`ifdef NAN_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [31:0]        y_init;
  logic [STEPS_W-1:0] n_steps;
  logic [31:0]        neuron_y_t;
  logic [31:0]        neuron_y_next;
  logic               busy;
  logic               done;
  logic               err;
  logic [STEPS_W-1:0] step_count;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [STEPS_W-1:0] out_step;

  ctrnn_step_sequencer #(
    .STEPS_W   (STEPS_W),
    .LAT       (LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .y_init       (y_init),
    .n_steps      (n_steps),
    .neuron_y_t   (neuron_y_t),
    .neuron_y_next(neuron_y_next),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .step_count   (step_count),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_step     (out_step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected trace entries {step, value} in push order.
  logic [47:0] exp_q [$];

  logic        nan_en = 1'b0;
  logic [31:0] nan_at = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Stub neuron rule: bit pattern + 1, or a quiet NaN when the injected trigger value is seen.
  function automatic logic [31:0] stub_f(input logic [31:0] y);
    if (nan_en && y == nan_at) return 32'h7FC0_0000;
    return y + 32'd1;
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= stub_f(neuron_y_t);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign neuron_y_next = pipe[LAT-1];

  // Every accepted pop must match the head of the model trace.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_when_empty", {63'd0, out_valid}, 64'd0);
      end else begin
        logic [47:0] head;
        head = exp_q.pop_front();
        check("pop_step", 64'(out_step), 64'(head[47:32]));
        check("pop_data", 64'(out_data), 64'(head[31:0]));
      end
    end
  end

  // Predict the trace of one run; caps = number of capture decisions taken.
  task automatic build_model(input logic [31:0] yi, input int n,
                             output int good, output int caps, output bit e);
    logic [31:0] y;
    y = yi; good = 0; caps = 0; e = 1'b0;
    for (int k = 1; k <= n; k++) begin
      caps++;
      y = stub_f(y);
      if (GUARD && y[30:23] == 8'hFF) begin
        e = 1'b1;
        break;
      end
      exp_q.push_back({16'(k), y});
      good++;
    end
  endtask

  // Drive start; returns #1 after the sampling edge E.
  task automatic start_run(input logic [31:0] yi, input int n);
    @(posedge clk); #1;
    start   = 1'b1;
    y_init  = yi;
    n_steps = STEPS_W'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    y_init  = $urandom;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    if (n != 0) check("y_t_loaded", 64'(neuron_y_t), 64'(yi));
    if (GUARD) check("err_cleared", {63'd0, err}, 64'd0);
  endtask

  // Counts negedges after E until done; kd = -1 on timeout.
  task automatic wait_done(input int budget, input bit rand_ready, input bit busy_start,
                           output int kd);
    kd = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (done) begin
        kd = k;
        break;
      end
      @(posedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = busy_start && (k == LAT + 3);
      y_init    = 32'h1234_5678;
      n_steps   = STEPS_W'(7);
    end
    start = 1'b0;
    if (kd < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_run(input int good, input bit e);
    check("step_count_at_done", 64'(step_count), 64'(good));
    check("err_at_done", {63'd0, err}, {63'd0, e});
    check("busy_at_done", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("busy_fall", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 4 * FIFO_DEPTH; i++) begin
      if (!out_valid) break;
      @(negedge clk);
    end
    check("trace_drained", 64'(exp_q.size()), 64'd0);
    check("fifo_empty", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic do_run(input logic [31:0] yi, input int n, input bit rand_ready,
                        input bit check_timing, input bit busy_start);
    int good, caps, kd;
    bit e;
    build_model(yi, n, good, caps, e);
    out_ready = 1'b1;
    start_run(yi, n);
    wait_done(4000, rand_ready, busy_start, kd);
    if (check_timing && kd >= 0) check("done_latency", 64'(kd), 64'(caps * (LAT + 1) + 1));
    finish_run(good, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y_t"}, 64'(neuron_y_t), 64'd0);
    check({tag, "_flags"}, {60'd0, busy, done, err, out_valid}, 64'd0);
    check({tag, "_step_count"}, 64'(step_count), 64'd0);
    check({tag, "_out"}, {16'd0, out_step, out_data}, 64'd0);
  endtask

  initial begin
    int good, caps, kd;
    bit e;
    logic [31:0] yi;

    rst = 1'b0; start = 1'b0; y_init = '0; n_steps = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Basic run with exact done timing.
    do_run(32'h3F80_0000, 3, 1'b0, 1'b1, 1'b0);

    // Zero steps: done one cycle after start, no samples.
    do_run(32'h4000_0000, 0, 1'b0, 1'b1, 1'b0);

    // Start while busy is ignored.
    do_run(32'h3F00_0010, 4, 1'b0, 1'b1, 1'b1);

    // Backpressure: stall after FIFO_DEPTH pushes, then drain all 12 in order.
    yi = 32'h4120_0000;
    build_model(yi, 12, good, caps, e);
    out_ready = 1'b0;
    start_run(yi, 12);
    repeat (FIFO_DEPTH * (LAT + 1) + 10) @(negedge clk);
    check("bp_step_count", 64'(step_count), 64'(FIFO_DEPTH));
    check("bp_flags", {62'd0, busy, out_valid}, 64'd3);
    check("bp_y_t", 64'(neuron_y_t), 64'(exp_q[FIFO_DEPTH-1][31:0]));
    check("bp_head_step", 64'(out_step), 64'd1);
    repeat (5) @(negedge clk);
    check("bp_y_t_stable", 64'(neuron_y_t), 64'(exp_q[FIFO_DEPTH-1][31:0]));
    check("bp_still_stalled", 64'(step_count), 64'(FIFO_DEPTH));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(500, 1'b0, 1'b0, kd);
    finish_run(good, e);

    // Reset during WAIT of step 2, then a clean basic run.
    yi = 32'h3F80_0000;
    build_model(yi, 3, good, caps, e);
    out_ready = 1'b1;
    start_run(yi, 3);
    repeat (LAT + 2) @(posedge clk);
    #2;
    check("pre_reset_step_count", 64'(step_count), 64'd1);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    do_run(32'h3F80_0000, 3, 1'b0, 1'b1, 1'b0);

    // Non-finite value at step 2.
    yi = 32'h3E00_0100;
    nan_en = 1'b1;
    nan_at = yi + 32'd1;
    do_run(yi, 4, 1'b0, 1'b1, 1'b0);
    nan_en = 1'b0;

    // Randomized runs, alternating free-flowing and random backpressure.
    for (int r = 0; r < 8; r++) begin
      yi = {9'h07E, 23'($urandom)};
      do_run(yi, $urandom_range(1, 10), r[0], !r[0], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
